// File: rtl/ej32_fetch.sv
// eJ32 instruction fetch / operand assembly: memory address mux, fetch address p,
// opcode register, immediate shift register and retired-opcode counter.
module ej32_fetch #(
   parameter int unsigned    ASZ  = 17,
   parameter logic [ASZ-1:0] COLD = '0,
   parameter logic [7:0]     NOP  = 8'h00
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [ASZ-1:0] dc_p_o,
   input  logic           dc_code,
   input  logic           br_ld,
   input  logic [ASZ-1:0] br_tgt,
   input  logic           ls_sel,
   input  logic [ASZ-1:0] ls_addr,
   input  logic           halt,
   input  logic [7:0]     mem_data,
   output logic [ASZ-1:0] mem_addr,
   output logic           mem_rd,
   output logic [ASZ-1:0] p,
   output logic [7:0]     code,
   output logic [31:0]    ir,
   output logic [31:0]    icnt
);

   typedef enum logic {RUN = 1'b0, BRP = 1'b1} state_t;

   state_t         state, state_nxt;
   logic [ASZ-1:0] pend, pend_nxt;
   logic           fv;
   logic           bus_busy;

   assign bus_busy = ls_sel | halt;

   // Address mux and branch-pending next state; a deferred branch is issued
   // on the first cycle the bus is free again.
   always_comb begin
      mem_addr  = dc_p_o;
      mem_rd    = 1'b1;
      state_nxt = state;
      pend_nxt  = pend;

      if (!rst) begin
         mem_addr = COLD;
         mem_rd   = 1'b0;
      end else if (ls_sel) begin
         mem_addr = ls_addr;
         mem_rd   = 1'b0;
      end else if (halt) begin
         mem_addr = p;
         mem_rd   = 1'b0;
      end else if (state == BRP) begin
         mem_addr = pend;
      end else if (br_ld) begin
         mem_addr = br_tgt;
      end

      case (state)
         RUN: begin
            if (br_ld && bus_busy) begin
               state_nxt = BRP;
               pend_nxt  = br_tgt;
            end
         end
         BRP: begin
            if (br_ld) begin
               pend_nxt = br_tgt;
            end
            if (!bus_busy && !br_ld) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // State, fetch address and opcode/operand capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         pend  <= '0;
         p     <= COLD;
         code  <= NOP;
         ir    <= '0;
         icnt  <= '0;
         fv    <= 1'b0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
         fv    <= mem_rd;
         if (mem_rd) begin
            p <= mem_addr;
         end
         if (dc_code) begin
            if (fv) begin
               code <= mem_data;
               ir   <= '0;
               icnt <= icnt + 32'd1;
            end else begin
               code <= NOP;
            end
         end else if (fv) begin
            ir <= {ir[23:0], mem_data};
         end
      end
   end

endmodule

// File: tb/tb_ej32_fetch.sv
// Scoreboard bench for ej32_fetch: directed scenarios followed by random traffic,
// checked against a transaction-level model of the fetch stage.
module tb_ej32_fetch;

   localparam int unsigned    ASZ  = 17;
   localparam logic [ASZ-1:0] COLD = '0;
   localparam logic [7:0]     NOP  = 8'h00;

   logic           clk = 1'b0;
   logic           rst;
   logic [ASZ-1:0] dc_p_o, br_tgt, ls_addr;
   logic           dc_code, br_ld, ls_sel, halt;
   logic [7:0]     mem_data;
   logic [ASZ-1:0] mem_addr, p;
   logic           mem_rd;
   logic [7:0]     code;
   logic [31:0]    ir, icnt;

   always #5 clk = ~clk;

   ej32_fetch #(.ASZ(ASZ), .COLD(COLD), .NOP(NOP)) dut (
      .clk(clk), .rst(rst), .dc_p_o(dc_p_o), .dc_code(dc_code),
      .br_ld(br_ld), .br_tgt(br_tgt), .ls_sel(ls_sel), .ls_addr(ls_addr),
      .halt(halt), .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .p(p), .code(code), .ir(ir), .icnt(icnt)
   );

   // Synchronous byte memory, one cycle of latency.
   logic [7:0] mem [0:(1<<ASZ)-1];
   always @(posedge clk) mem_data <= mem[mem_addr];

   typedef struct {
      logic [ASZ-1:0] addr;
      logic           rd;
   } comb_exp_t;

   typedef struct {
      logic [ASZ-1:0] p;
      logic [7:0]     code;
      logic [31:0]    ir;
      logic [31:0]    icnt;
   } reg_exp_t;

   comb_exp_t comb_q[$];
   reg_exp_t  reg_q[$];
   int        checks   = 0;
   int        failures = 0;

   // Model: architectural view of the stage.
   logic [ASZ-1:0] m_p       = COLD;
   logic [7:0]     m_code    = NOP;
   logic [31:0]    m_ir      = '0;
   logic [31:0]    m_icnt    = '0;
   bit             m_fv      = 1'b0;
   bit             m_waiting = 1'b0;
   logic [ASZ-1:0] m_pend    = '0;
   logic [ASZ-1:0] m_last    = COLD;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; predicts this cycle's bus and the state after the edge.
   task automatic cycle(input logic r, input logic [ASZ-1:0] dcp, input logic dcc,
                        input logic br, input logic [ASZ-1:0] tgt,
                        input logic ls, input logic [ASZ-1:0] lsa, input logic hlt);
      comb_exp_t ce;
      reg_exp_t  re;
      logic [7:0] d;
      @(posedge clk);
      #2;
      rst = r; dc_p_o = dcp; dc_code = dcc; br_ld = br; br_tgt = tgt;
      ls_sel = ls; ls_addr = lsa; halt = hlt;

      if (!r)              begin ce.addr = COLD;   ce.rd = 1'b0; end
      else if (ls)         begin ce.addr = lsa;    ce.rd = 1'b0; end
      else if (hlt)        begin ce.addr = m_p;    ce.rd = 1'b0; end
      else if (m_waiting)  begin ce.addr = m_pend; ce.rd = 1'b1; end
      else if (br)         begin ce.addr = tgt;    ce.rd = 1'b1; end
      else                 begin ce.addr = dcp;    ce.rd = 1'b1; end
      comb_q.push_back(ce);

      d = mem[m_last];
      if (!r) begin
         m_p = COLD; m_code = NOP; m_ir = '0; m_icnt = '0;
         m_fv = 1'b0; m_waiting = 1'b0; m_pend = '0;
      end else begin
         if (dcc) begin
            if (m_fv) begin
               m_code = d; m_ir = '0; m_icnt = m_icnt + 32'd1;
            end else begin
               m_code = NOP;
            end
         end else if (m_fv) begin
            m_ir = {m_ir[23:0], d};
         end
         if (m_waiting) begin
            if (br) m_pend = tgt;
            if (!ls && !hlt) m_waiting = 1'b0;
         end else if (br && (ls || hlt)) begin
            m_waiting = 1'b1;
            m_pend    = tgt;
         end
         if (ce.rd) m_p = ce.addr;
         m_fv = ce.rd;
      end
      m_last = ce.addr;
      re.p = m_p; re.code = m_code; re.ir = m_ir; re.icnt = m_icnt;
      reg_q.push_back(re);
   endtask

   // Monitor: registered results just after the edge, bus mid-cycle.
   initial begin
      comb_exp_t ce;
      reg_exp_t  re;
      forever begin
         @(posedge clk);
         #1;
         if (reg_q.size() > 0) begin
            re = reg_q.pop_front();
            chk("p",    32'(p),    32'(re.p));
            chk("code", 32'(code), 32'(re.code));
            chk("ir",   ir,        re.ir);
            chk("icnt", icnt,      re.icnt);
         end
         #5;
         if (comb_q.size() > 0) begin
            ce = comb_q.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(ce.addr));
            chk("mem_rd",   32'(mem_rd),   32'(ce.rd));
         end
      end
   end

   initial begin
      logic [ASZ-1:0] dcp, tgt, lsa;
      logic           r, dcc, br, ls, hlt;
      rst = 1'b0; dc_p_o = '0; dc_code = 1'b0; br_ld = 1'b0; br_tgt = '0;
      ls_sel = 1'b0; ls_addr = '0; halt = 1'b0;
      for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'($urandom);
      mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h34;

      // Cold start and sipush stream
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 1, 0, 0, 0, 0, 0);
      cycle(1, 2, 1, 0, 0, 0, 0, 0);
      cycle(1, 3, 0, 0, 0, 0, 0, 0);
      cycle(1, 4, 0, 0, 0, 0, 0, 0);
      // Halt holds p and re-presents it on the bus
      cycle(1, 5, 0, 0, 0, 0, 0, 1);
      cycle(1, 5, 0, 0, 0, 0, 0, 1);
      cycle(1, 5, 1, 0, 0, 0, 0, 0);
      cycle(1, 6, 1, 0, 0, 0, 0, 0);
      // Mid-run reset
      cycle(0, 7, 1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      // Immediate branch
      cycle(1, 1, 1, 1, 17'h00100, 0, 0, 0);
      cycle(1, 17'h00101, 1, 0, 0, 0, 0, 0);
      cycle(1, 17'h00102, 1, 0, 0, 0, 0, 0);
      // Branch deferred behind three LS cycles
      cycle(1, 17'h00103, 0, 1, 17'h00200, 1, 17'h01000, 0);
      cycle(1, 17'h00103, 0, 0, 0, 1, 17'h01000, 0);
      cycle(1, 17'h00103, 0, 0, 0, 1, 17'h01000, 0);
      cycle(1, 17'h00103, 1, 0, 0, 0, 0, 0);
      cycle(1, 17'h00201, 1, 0, 0, 0, 0, 0);
      // Single LS cycle then opcode request sees a bubble
      cycle(1, 17'h00202, 0, 0, 0, 1, 17'h01234, 0);
      cycle(1, 17'h00202, 1, 0, 0, 0, 0, 0);
      cycle(1, 17'h00203, 1, 0, 0, 0, 0, 0);
      // Newest branch target wins while deferred
      cycle(1, 17'h00204, 0, 1, 17'h00300, 0, 0, 1);
      cycle(1, 17'h00204, 0, 1, 17'h00400, 1, 17'h00010, 1);
      cycle(1, 17'h00204, 1, 0, 0, 0, 0, 0);
      cycle(1, 17'h00401, 1, 0, 0, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 199) != 0);
         ls  = ($urandom_range(0, 4) == 0);
         hlt = ($urandom_range(0, 9) == 0);
         br  = ($urandom_range(0, 9) == 0);
         if (m_waiting && !ls && !hlt) br = 1'b0;
         dcc = ($urandom_range(0, 9) < 4);
         case ($urandom_range(0, 9))
            0:       dcp = ASZ'($urandom);
            1, 2:    dcp = m_p;
            default: dcp = ASZ'(m_p + 1'b1);
         endcase
         tgt = ASZ'($urandom);
         lsa = ASZ'($urandom);
         cycle(r, dcp, dcc, br, tgt, ls, lsa, hlt);
      end

      repeat (3) @(posedge clk);
      #8;
      chk("queues_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ej32_fetch.md
Name: ej32_fetch

Overview:
- Instruction fetch and operand-assembly stage directly upstream of the eJ32 decoder unit.
- Owns the memory address mux, the instruction address `p` fed to the decoder, and the opcode register `code`.
- Consumes the decoder's `dc_p_o` (next byte address) and `dc_code` (latch-opcode strobe). Also consumes branch-unit redirects and load/store bus requests.
- Shifts non-opcode bytes into a 32-bit immediate register for bipush/sipush/ldi and keeps a retired-opcode counter.

Parameters:
- COLD, 'h0, cold-start instruction address (matches the decoder's COLD).
- ASZ, 17, address width in bits.
- NOP, 8'h00, opcode injected as a bubble when no valid instruction byte is available.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- dc_p_o  input  ASZ  next sequential byte address from the decoder
- dc_code  input  1  1 = load the next valid byte as opcode; 0 = byte is an operand
- br_ld  input  1  branch taken this cycle
- br_tgt  input  ASZ  branch target address
- ls_sel  input  1  LS unit owns the memory bus this cycle
- ls_addr  input  ASZ  LS unit data address
- halt  input  1  freeze instruction fetch
- mem_data  input  8  byte returned for the previous cycle's mem_addr (synchronous memory, 1-cycle latency)
- mem_addr  output  ASZ  memory byte address (combinational)
- mem_rd  output  1  instruction-fetch read strobe (combinational)
- p  output  ASZ  address of the instruction byte currently on mem_data (to the decoder)
- code  output  8  current opcode (to decoder/control)
- ir  output  32  immediate shift register
- icnt  output  32  count of valid opcodes loaded

Behaviour:
- Reset (rst==0 at a clk edge, including mid-operation):
  - p=COLD, code=NOP, ir=0, icnt=0, fv=0, state=RUN, pend=0.
  - While rst==0: mem_rd=0 and mem_addr=COLD.
- Address mux (combinational), first match wins:
  1. ls_sel → ls_addr, mem_rd=0.
  2. halt → p, mem_rd=0.
  3. state==BRP → pend, mem_rd=1.
  4. br_ld → br_tgt, mem_rd=1.
  5. else → dc_p_o, mem_rd=1.
- Fetch-valid flag: fv <= mem_rd, registered. fv=1 means mem_data this cycle is an instruction byte at address p.
- p register: p <= mem_addr when mem_rd=1; otherwise p holds.
  - Decoder holding dc_p_o (its wait phases) therefore re-reads the same byte.
- Opcode/operand capture, each cycle:
  - dc_code=1, fv=1: code <= mem_data; ir <= 0; icnt <= icnt+1, wrapping modulo 2^32.
  - dc_code=1, fv=0: code <= NOP; ir holds; icnt holds.
  - dc_code=0, fv=1: ir <= {ir[23:0], mem_data}; code holds.
  - dc_code=0, fv=0: code and ir hold.
- Branch-pending FSM:
  - States: RUN, BRP.
  - RUN → BRP when br_ld=1 and (ls_sel=1 or halt=1); pend <= br_tgt.
  - BRP → RUN on the first cycle with ls_sel=0 and halt=0; pend is issued as mem_addr that cycle.
  - br_ld asserted while in BRP overwrites pend; the newest target wins, and the state stays BRP until issued.
  - br_ld with ls_sel=0 and halt=0 in RUN issues br_tgt immediately. The target byte appears on mem_data next cycle with fv=1; no extra bubble.
- Latency: address issued at cycle N → byte captured at edge N+1 → code/ir visible in cycle N+2.
- Widths:
  - All address arithmetic is done by the decoder; this block does no incrementing.
  - p wraps naturally with dc_p_o at 2^ASZ.
  - ir keeps only the last four operand bytes; older bytes shift out.
- Simultaneous ls_sel and halt: ls_sel wins the bus; p holds; fv=0 next cycle.

Test Plan:
- Reset, then mem returns 0x10 at COLD with dc_code=1 → cycle 1: mem_addr=0, mem_rd=1; cycle 2: p=0, fv=1; after the capture edge code=0x10, icnt=1. Assert rst=0 mid-run → p=0, code=0x00, ir=0, icnt=0 on the next edge.
- sipush stream 0x11,0x12,0x34 with dc_code pattern 1,0,0 → code=0x11, ir=0x00001234, icnt=1.
- br_ld=1, br_tgt=0x0100, ls_sel=0 → mem_addr=0x0100 that cycle; next cycle p=0x0100, fv=1; with dc_code=1, code=mem_data byte at 0x0100.
- br_ld=1, br_tgt=0x0200 while ls_sel=1 for 3 cycles, ls_addr=0x1000 → mem_addr=0x1000 and mem_rd=0 for 3 cycles, state=BRP; 4th cycle mem_addr=0x0200, state=RUN.
- ls_sel=1 for 1 cycle with dc_code=1 on the following cycle → fv=0, code=NOP (0x00), icnt unchanged, p unchanged.
- halt=1 for 2 cycles with dc_p_o=0x0005, p=0x0004 → mem_addr=0x0004, mem_rd=0, no code/ir change. After halt drops: mem_addr=0x0005, and the next p=0x0005.
